// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment bit positions and the hex glyph table.
// Patterns are active-high, bit0 = a .. bit6 = g.
package seg7_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Entries written g..a, indexed by the 4-bit digit value
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b0111111,  // 0
    7'b0000110,  // 1
    7'b1011011,  // 2
    7'b1001111,  // 3
    7'b1100110,  // 4
    7'b1101101,  // 5
    7'b1111101,  // 6
    7'b0000111,  // 7
    7'b1111111,  // 8
    7'b1101111,  // 9
    7'b1110111,  // A
    7'b1111100,  // b
    7'b0111001,  // C
    7'b1011110,  // d
    7'b1111001,  // E
    7'b1110001   // F
  };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex-to-segment decoder producing the active-high pattern.
module seg7_decoder (
  input  logic [3:0] value,
  output logic [6:0] pattern
);
  import seg7_pkg::*;

  logic [6:0] row;

  // Segment order on the bus is tied to the named positions, not to table layout
  always_comb begin
    // NOTE: every combinational output is given a default first so no latch can be inferred.
    row     = SEG_TABLE[value];
    pattern = '0;
    pattern[SEG_A] = row[SEG_A];
    pattern[SEG_B] = row[SEG_B];
    pattern[SEG_C] = row[SEG_C];
    pattern[SEG_D] = row[SEG_D];
    pattern[SEG_E] = row[SEG_E];
    pattern[SEG_F] = row[SEG_F];
    pattern[SEG_G] = row[SEG_G];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment driver: shadow capture, slot prescaler, digit scan,
// leading-zero and global blanking, polarity adjust and registered outputs.
module seg7_scan_driver #(
  parameter int NB_DIGITS           = 4,
  parameter int PRESCALE            = 50000,
  parameter int SEG_POLARITY        = 0,
  parameter int AN_POLARITY         = 0,
  parameter int BLANK_LEADING_ZEROS = 1
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [4*NB_DIGITS-1:0] Digits,
  input  logic [NB_DIGITS-1:0]   DpMask,
  input  logic                   Load,
  input  logic                   Blank,
  output logic [6:0]             Seg,
  output logic                   Dp,
  output logic [NB_DIGITS-1:0]   An,
  output logic                   ScanTick
);
  import seg7_pkg::*;

  localparam int   PS_W    = $clog2(PRESCALE);
  localparam int   IDX_W   = (NB_DIGITS > 1) ? $clog2(NB_DIGITS) : 1;
  localparam logic AN_INV  = (AN_POLARITY == 0);
  localparam logic SEG_INV = (SEG_POLARITY == 0);

  logic [PS_W-1:0]        prescaler;
  logic [IDX_W-1:0]       index;
  logic [4*NB_DIGITS-1:0] shadowDigits;
  logic [NB_DIGITS-1:0]   shadowDp;
  logic                   tick;

  logic [NB_DIGITS-1:0] lzBlank;
  logic [NB_DIGITS-1:0] anOneHot;
  logic [3:0]           selDigit;
  logic                 selDp;
  logic                 selBlank;
  logic                 slotOff;
  logic                 upperZero;
  logic [6:0]           pattern;

  assign tick = (prescaler == PS_W'(PRESCALE - 1));

  // A digit is a leading zero when it and every more significant digit are zero
  always_comb begin
    upperZero = 1'b1;
    lzBlank   = '0;
    for (int i = NB_DIGITS - 1; i >= 0; i--) begin
      upperZero  = upperZero && (shadowDigits[i*4 +: 4] == 4'd0);
      lzBlank[i] = (BLANK_LEADING_ZEROS != 0) && (i != 0) && upperZero;
    end
  end

  always_comb begin
    selDigit = '0;
    selDp    = 1'b0;
    selBlank = 1'b0;
    anOneHot = '0;
    for (int i = 0; i < NB_DIGITS; i++) begin
      if (index == IDX_W'(i)) begin
        selDigit    = shadowDigits[i*4 +: 4];
        selDp       = shadowDp[i];
        selBlank    = lzBlank[i];
        anOneHot[i] = 1'b1;
      end
    end
  end

  assign slotOff = Blank || selBlank;

  seg7_decoder uDecoder (
    .value   (selDigit),
    .pattern (pattern)
  );

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (Reset) begin
      prescaler    <= '0;
      index        <= '0;
      // NOTE: the shadow registers are reset because a cleared shadow must show a single 0 afterwards.
      shadowDigits <= '0;
      shadowDp     <= '0;
      ScanTick     <= 1'b0;
      An           <= {NB_DIGITS{AN_INV}};
      Seg          <= {7{SEG_INV}};
      Dp           <= SEG_INV;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) begin
        index <= (index == IDX_W'(NB_DIGITS - 1)) ? '0 : index + 1'b1;
      end
      if (Load) begin
        shadowDigits <= Digits;
        shadowDp     <= DpMask;
      end
      ScanTick <= tick;
      // Outputs are decoded in active-high form, then flipped to the pin polarity
      An  <= (slotOff ? '0 : anOneHot) ^ {NB_DIGITS{AN_INV}};
      Seg <= (slotOff ? 7'd0 : pattern) ^ {7{SEG_INV}};
      Dp  <= (!slotOff && selDp) ^ SEG_INV;
    end
  end

endmodule
